// File: rtl/gpu_batch_scheduler_if.sv
// Vertex-stream input and batch-output bundle for gpu_batch_scheduler.
// slave: the scheduler side. master: the producer/consumer side.
interface gpu_batch_scheduler_if #(
  parameter int BATCH = 10
);
  logic                   v_valid;
  logic                   v_ready;
  logic [31:0]            v_x;
  logic [31:0]            v_y;
  logic [31:0]            v_z;
  logic                   out_valid;
  logic [BATCH-1:0][31:0] out_x;
  logic [BATCH-1:0][31:0] out_y;
  logic [BATCH-1:0][31:0] out_z;
  logic [BATCH-1:0]       out_lane_mask;

  modport master (
    output v_valid, v_x, v_y, v_z,
    input  v_ready, out_valid, out_x, out_y, out_z, out_lane_mask
  );

  modport slave (
    input  v_valid, v_x, v_y, v_z,
    output v_ready, out_valid, out_x, out_y, out_z, out_lane_mask
  );
endinterface

// File: rtl/gpu_batch_scheduler.sv
// gpu_batch_scheduler: gathers a frame's Q16.16 vertex stream into
// BATCH-lane batches, issues them to the vertex shader while keeping at most
// MAX_INFLIGHT batches outstanding, and reports frame completion.
// Optional feature macro: GPU_SCHED_PERF_EN adds perf_busy_cycles and
// perf_stall_cycles saturating counters.
module gpu_batch_scheduler #(
  parameter int BATCH        = 10,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_go,
  input  logic [15:0] frame_vcount,
  gpu_batch_scheduler_if.slave bus,
  output logic        out_frame_start,
  input  logic        done_in,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] batches_issued,
  output logic        err_underflow
`ifdef GPU_SCHED_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_stall_cycles
`endif
);
  localparam int FW = $clog2(BATCH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FILL, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [FW-1:0]          fill;
  logic [15:0]            remaining;
  logic [IW-1:0]          inflight;
  logic [BATCH-1:0][31:0] lane_x;
  logic [BATCH-1:0][31:0] lane_y;
  logic [BATCH-1:0][31:0] lane_z;
  logic [BATCH-1:0]       lane_mask;
  logic                   v_ready;
  logic                   out_valid;
  logic                   accept;

  assign accept            = v_ready && bus.v_valid;
  assign bus.v_ready       = v_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_x         = lane_x;
  assign bus.out_y         = lane_y;
  assign bus.out_z         = lane_z;
  assign bus.out_lane_mask = lane_mask;

  // State register.
  // NOTE: flops use non-blocking (<=) so every register samples pre-edge
  // values; blocking assignments here would make results depend on block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-state strobes.
  // NOTE: every signal gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    v_ready         = 1'b0;
    out_valid       = 1'b0;
    out_frame_start = 1'b0;
    frame_done      = 1'b0;
    busy            = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (frame_go) state_nxt = (frame_vcount != 16'd0) ? S_START : S_DONE;
      end
      S_START: begin
        out_frame_start = 1'b1;
        state_nxt       = S_FILL;
      end
      S_FILL: begin
        v_ready = (fill < FW'(BATCH)) && (remaining != 16'd0);
        // The handshake that fills the last lane or takes the last vertex ends the batch.
        if (v_ready && bus.v_valid &&
            ((fill + 1'b1 == FW'(BATCH)) || (remaining == 16'd1)))
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (inflight < IW'(MAX_INFLIGHT)) begin
          out_valid = 1'b1;
          state_nxt = (remaining != 16'd0) ? S_FILL : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane mask: lowest `fill` bits, presented only while a batch is offered.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BATCH; i++) lane_mask[i] = out_valid && (fill > FW'(i));
  end

  // Frame bookkeeping and lane capture. The first handshake of a batch
  // zeroes the other lanes, so unfilled lanes read zero at issue and the
  // issued contents hold until the next batch starts filling.
  // NOTE: the lane registers are reset as well, because the lanes drive the
  // outputs directly and must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill           <= '0;
      remaining      <= '0;
      batches_issued <= '0;
      lane_x         <= '0;
      lane_y         <= '0;
      lane_z         <= '0;
    end else begin
      if (state == S_IDLE && frame_go) remaining <= frame_vcount;
      if (state == S_START) begin
        fill           <= '0;
        batches_issued <= '0;
      end
      if (accept) begin
        for (int i = 0; i < BATCH; i++) begin
          if (FW'(i) == fill) begin
            lane_x[i] <= bus.v_x;
            lane_y[i] <= bus.v_y;
            lane_z[i] <= bus.v_z;
          end else if (fill == '0) begin
            lane_x[i] <= '0;
            lane_y[i] <= '0;
            lane_z[i] <= '0;
          end
        end
        fill      <= fill + 1'b1;
        remaining <= remaining - 16'd1;
      end
      if (out_valid) begin
        fill           <= '0;
        batches_issued <= batches_issued + 16'd1;
      end
    end
  end

  // Outstanding-batch count; a completion with nothing outstanding and no
  // simultaneous issue flags a sticky underflow instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else if (out_valid && !done_in) begin
      inflight <= inflight + 1'b1;
    end else if (!out_valid && done_in) begin
      if (inflight != '0) inflight      <= inflight - 1'b1;
      else                err_underflow <= 1'b1;
    end
  end

`ifdef GPU_SCHED_PERF_EN
  // Busy and issue-stall cycle counters, cleared at each frame start, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (state == S_START) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == S_ISSUE && inflight == IW'(MAX_INFLIGHT) && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_batch_scheduler.sv
// Self-checking bench for gpu_batch_scheduler: random vertex streams and
// completion timing, checked against a batch-slicing reference model.
module tb_gpu_batch_scheduler;
  localparam int BATCH = 10;
  localparam int MAXI  = 4;

  typedef struct { logic [31:0] x, y, z; } vert_t;
  typedef struct {
    logic [BATCH-1:0][31:0] x, y, z;
    logic [BATCH-1:0]       mask;
  } batch_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_go = 1'b0;
  logic [15:0] frame_vcount = '0;
  logic        done_in = 1'b0;
  logic        out_frame_start, busy, frame_done, err_underflow;
  logic [15:0] batches_issued;
`ifdef GPU_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

  gpu_batch_scheduler_if #(.BATCH(BATCH)) bus ();

  gpu_batch_scheduler #(.BATCH(BATCH), .MAX_INFLIGHT(MAXI)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_go        (frame_go),
    .frame_vcount    (frame_vcount),
    .bus             (bus),
    .out_frame_start (out_frame_start),
    .done_in         (done_in),
    .busy            (busy),
    .frame_done      (frame_done),
    .batches_issued  (batches_issued),
    .err_underflow   (err_underflow)
`ifdef GPU_SCHED_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus and observation state shared by the sequential test tasks.
  vert_t  sent[$];
  vert_t  send_q[$];
  batch_t got_q[$];
  int     issue_cyc_q[$];
  int     due_q[$];
  int     cyc = 0;
  bit     hold_valid, withhold, go_now, timed_out;
  int     done_lat, go_n, go_cyc, stray_off, stray_cyc;
  int     hs_cnt, fs_cnt, fd_cnt, busy_cnt, busy_first, first_ready, last_hs, fs_cyc, fd_cyc;

  // Reference model: batch b of an n-vertex frame is the next BATCH vertices
  // in arrival order; lanes past the end of the frame are zero and unmasked.
  function automatic batch_t model_batch(input int b, input int n);
    batch_t e;
    int cnt;
    cnt = n - b * BATCH;
    if (cnt > BATCH) cnt = BATCH;
    e.x = '0; e.y = '0; e.z = '0; e.mask = '0;
    for (int i = 0; i < cnt; i++) begin
      e.x[i] = sent[b * BATCH + i].x;
      e.y[i] = sent[b * BATCH + i].y;
      e.z[i] = sent[b * BATCH + i].z;
      e.mask[i] = 1'b1;
    end
    return e;
  endfunction

  function automatic int first_bad_lane(input batch_t g, input batch_t e);
    for (int i = 0; i < BATCH; i++)
      if (g.x[i] !== e.x[i] || g.y[i] !== e.y[i] || g.z[i] !== e.z[i]) return i;
    return -1;
  endfunction

  // Schedule a done_in pulse, keeping the schedule sorted and one pulse per cycle.
  function automatic void insert_due(input int c);
    int k = 0;
    while (k < due_q.size() && due_q[k] <= c) begin
      if (due_q[k] == c) c++;
      k++;
    end
    due_q.insert(k, c);
  endfunction

  // One clock cycle: observe outputs at the falling edge, then drive inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.out_valid) begin
      batch_t g;
      g.x = bus.out_x; g.y = bus.out_y; g.z = bus.out_z; g.mask = bus.out_lane_mask;
      got_q.push_back(g);
      issue_cyc_q.push_back(cyc);
      if (!withhold) insert_due(cyc + done_lat);
    end
    if (out_frame_start) begin fs_cnt++; fs_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (busy) begin busy_cnt++; if (busy_first < 0) busy_first = cyc; end
    if (bus.v_ready && first_ready < 0) first_ready = cyc;
    frame_go = 1'b0;
    if (go_now) begin
      frame_go = 1'b1; frame_vcount = 16'(go_n); go_cyc = cyc; go_now = 1'b0;
      stray_cyc = (stray_off > 0) ? cyc + stray_off : -1;
    end else if (cyc == stray_cyc) begin
      frame_go = 1'b1; frame_vcount = 16'($urandom_range(1, 100));
    end
    done_in = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin done_in = 1'b1; void'(due_q.pop_front()); end
    if (send_q.size() > 0 && (hold_valid || $urandom_range(0, 2) != 0)) begin
      bus.v_valid = 1'b1; bus.v_x = send_q[0].x; bus.v_y = send_q[0].y; bus.v_z = send_q[0].z;
    end else begin
      bus.v_valid = 1'b0; bus.v_x = $urandom; bus.v_y = $urandom; bus.v_z = $urandom;
    end
    if (bus.v_valid && bus.v_ready) begin void'(send_q.pop_front()); hs_cnt++; last_hs = cyc; end
  endtask

  task automatic setup_frame(input int n, input bit hold, input int lat, input bit wh, input int stray);
    vert_t v;
    sent.delete(); send_q.delete(); got_q.delete(); issue_cyc_q.delete(); due_q.delete();
    for (int i = 0; i < n; i++) begin
      v.x = $urandom; v.y = $urandom; v.z = $urandom;
      sent.push_back(v); send_q.push_back(v);
    end
    hold_valid = hold; done_lat = lat; withhold = wh; stray_off = stray; stray_cyc = -1;
    hs_cnt = 0; fs_cnt = 0; fd_cnt = 0; busy_cnt = 0; busy_first = -1; first_ready = -1;
    last_hs = -1; fs_cyc = -1; fd_cyc = -1; go_n = n; go_now = 1'b1;
  endtask

  task automatic run_until_done(input int max_cyc);
    int t0 = cyc;
    while (fd_cnt == 0 && (cyc - t0) < max_cyc) step();
    timed_out = (fd_cnt == 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (bus.v_ready !== 1'b0) begin bad++; $display("FAIL reset_v_ready: got %b want 0", bus.v_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if ({out_frame_start, frame_done, err_underflow} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got %b want 000", {out_frame_start, frame_done, err_underflow}); end
    total++; if (bus.out_lane_mask !== '0 || batches_issued !== 16'd0) begin
      bad++; $display("FAIL reset_mask_count: got mask=%h issued=%0d want 0/0", bus.out_lane_mask, batches_issued); end
    total++; if ({bus.out_x, bus.out_y, bus.out_z} !== '0) begin
      bad++; $display("FAIL reset_lanes: got nonzero=%b want 0", |{bus.out_x, bus.out_y, bus.out_z}); end
    reset = 1'b1;
  endtask

  task automatic test_zero_frame();
    setup_frame(0, 1'b1, 1, 1'b0, 0);
    run_until_done(20);
    repeat (2) step();
    total++; if (timed_out || fd_cyc != go_cyc + 1) begin
      bad++; $display("FAIL zero_done_cycle: got %0d want %0d", fd_cyc - go_cyc, 1); end
    total++; if (fs_cnt != 0) begin bad++; $display("FAIL zero_frame_start: got %0d want 0", fs_cnt); end
    total++; if (busy_cnt != 1 || busy_first != go_cyc + 1) begin
      bad++; $display("FAIL zero_busy: got cnt=%0d at=%0d want 1 at %0d", busy_cnt, busy_first - go_cyc, 1); end
  endtask

  task automatic test_single_batch();
    batch_t e;
    int li;
    setup_frame(10, 1'b1, 3, 1'b0, 0);
    run_until_done(200);
    e = model_batch(0, 10);
    total++; if (timed_out) begin bad++; $display("FAIL single_timeout: got no frame_done want frame_done"); end
    total++; if (fs_cyc != go_cyc + 1) begin bad++; $display("FAIL single_start_lat: got %0d want 1", fs_cyc - go_cyc); end
    total++; if (first_ready != go_cyc + 2) begin bad++; $display("FAIL single_ready_lat: got %0d want 2", first_ready - go_cyc); end
    total++; if (hs_cnt != 10) begin bad++; $display("FAIL single_handshakes: got %0d want 10", hs_cnt); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_batches: got %0d want 1", got_q.size()); end
    else begin
      total++; if (got_q[0].mask !== 10'h3FF) begin bad++; $display("FAIL single_mask: got %h want 3ff", got_q[0].mask); end
      li = first_bad_lane(got_q[0], e);
      total++; if (li >= 0) begin bad++; $display("FAIL single_lane %0d: got %h want %h", li, got_q[0].x[li], e.x[li]); end
      total++; if (issue_cyc_q[0] != last_hs + 1) begin bad++; $display("FAIL single_issue_lat: got %0d want 1", issue_cyc_q[0] - last_hs); end
      total++; if (fd_cyc != issue_cyc_q[0] + 3 + 2) begin bad++; $display("FAIL single_done_lat: got %0d want 5", fd_cyc - issue_cyc_q[0]); end
    end
    total++; if (batches_issued !== 16'd1) begin bad++; $display("FAIL single_issued: got %0d want 1", batches_issued); end
  endtask

  task automatic test_partial_batch();
    batch_t e;
    int li;
    setup_frame(23, 1'b0, $urandom_range(1, 5), 1'b0, 0);
    run_until_done(400);
    total++; if (timed_out || got_q.size() != 3) begin bad++; $display("FAIL partial_batches: got %0d want 3", got_q.size()); end
    else begin
      total++; if ({got_q[0].mask, got_q[1].mask, got_q[2].mask} !== {10'h3FF, 10'h3FF, 10'h007}) begin
        bad++; $display("FAIL partial_masks: got %h %h %h want 3ff 3ff 007", got_q[0].mask, got_q[1].mask, got_q[2].mask); end
      total++; if ({got_q[2].x[9:3], got_q[2].y[9:3], got_q[2].z[9:3]} !== '0) begin
        bad++; $display("FAIL partial_tail_zero: got lane3 x=%h want 0", got_q[2].x[3]); end
      for (int b = 0; b < 3; b++) begin
        e = model_batch(b, 23);
        li = first_bad_lane(got_q[b], e);
        total++; if (li >= 0) begin bad++; $display("FAIL partial_lane b%0d l%0d: got %h want %h", b, li, got_q[b].x[li], e.x[li]); end
      end
    end
    total++; if (batches_issued !== 16'd3) begin bad++; $display("FAIL partial_issued: got %0d want 3", batches_issued); end
  endtask

  task automatic test_inflight_stall();
    batch_t e;
    int li, t0, d_cyc;
    setup_frame(60, 1'b1, 8, 1'b1, 0);
    t0 = cyc;
    while (got_q.size() < 4 && (cyc - t0) < 300) step();
    repeat (15) step();
    total++; if (got_q.size() != 4 || hs_cnt != 50) begin
      bad++; $display("FAIL stall_count: got issues=%0d hs=%0d want 4/50", got_q.size(), hs_cnt); end
    total++; if ({bus.v_ready, bus.out_valid, busy} !== 3'b001) begin
      bad++; $display("FAIL stall_hold: got ready/valid/busy=%b want 001", {bus.v_ready, bus.out_valid, busy}); end
    withhold = 1'b0;
    d_cyc = cyc + 1;
    insert_due(d_cyc);
    step(); step();
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL stall_release: got %0d issues want 5", got_q.size()); end
    else if (issue_cyc_q[4] != d_cyc + 1) begin
      bad++; $display("FAIL stall_release: got lat %0d want 1", issue_cyc_q[4] - d_cyc); end
    insert_due(cyc + 2); insert_due(cyc + 3); insert_due(cyc + 4);
    run_until_done(400);
    total++; if (timed_out || got_q.size() != 6) begin bad++; $display("FAIL stall_batches: got %0d want 6", got_q.size()); end
    else begin
      for (int b = 0; b < 6; b++) begin
        e = model_batch(b, 60);
        li = first_bad_lane(got_q[b], e);
        total++; if (li >= 0 || got_q[b].mask !== e.mask) begin
          bad++; $display("FAIL stall_batch b%0d: got mask=%h lane=%0d want mask=%h", b, got_q[b].mask, li, e.mask); end
      end
    end
    total++; if (batches_issued !== 16'd6 || err_underflow !== 1'b0) begin
      bad++; $display("FAIL stall_issued: got %0d err=%b want 6/0", batches_issued, err_underflow); end
  endtask

  task automatic test_random_frames();
    batch_t e;
    int n, nb, li;
    for (int f = 0; f < 5; f++) begin
      n  = $urandom_range(1, 45);
      nb = (n + BATCH - 1) / BATCH;
      setup_frame(n, 1'($urandom_range(0, 1)), $urandom_range(1, 6), 1'b0, (f % 2 == 0) ? 4 : 0);
      run_until_done(1000);
      total++; if (timed_out || got_q.size() != nb || fs_cnt != 1) begin
        bad++; $display("FAIL rand%0d_batches: got %0d starts=%0d want %0d/1 (n=%0d)", f, got_q.size(), fs_cnt, nb, n); end
      else begin
        for (int b = 0; b < nb; b++) begin
          e = model_batch(b, n);
          li = first_bad_lane(got_q[b], e);
          total++; if (li >= 0 || got_q[b].mask !== e.mask) begin
            bad++; $display("FAIL rand%0d_batch b%0d: got mask=%h lane=%0d want mask=%h", f, b, got_q[b].mask, li, e.mask); end
        end
      end
      total++; if (batches_issued !== 16'(nb) || hs_cnt != n) begin
        bad++; $display("FAIL rand%0d_counts: got issued=%0d hs=%0d want %0d/%0d", f, batches_issued, hs_cnt, nb, n); end
    end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL rand_underflow: got %b want 0", err_underflow); end
  endtask

  task automatic test_underflow_and_reset();
    int t0;
    step();
    insert_due(cyc + 1);
    step(); step();
    total++; if (err_underflow !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_underflow: got err=%b busy=%b want 1/0", err_underflow, busy); end
    // With inflight still 0, four batches must issue before the stall.
    setup_frame(45, 1'b1, 1, 1'b1, 0);
    t0 = cyc;
    while (hs_cnt < 43 && (cyc - t0) < 300) step();
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL underflow_inflight: got %0d issues want 4", got_q.size()); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if ({bus.v_ready, bus.out_valid, busy, out_frame_start, frame_done, err_underflow} !== 6'b0) begin
      bad++; $display("FAIL midfill_reset_flags: got %b want 000000",
                      {bus.v_ready, bus.out_valid, busy, out_frame_start, frame_done, err_underflow}); end
    total++; if (batches_issued !== 16'd0 || bus.out_lane_mask !== '0 || {bus.out_x, bus.out_y, bus.out_z} !== '0) begin
      bad++; $display("FAIL midfill_reset_data: got issued=%0d mask=%h want 0/0", batches_issued, bus.out_lane_mask); end
    send_q.delete(); due_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) step();
    total++; if (fd_cnt != 0) begin bad++; $display("FAIL midfill_no_done: got %0d frame_done want 0", fd_cnt); end
    insert_due(cyc + 1);
    step(); step();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL post_reset_underflow: got %b want 1", err_underflow); end
  endtask

  initial begin
    bus.v_valid = 1'b0; bus.v_x = '0; bus.v_y = '0; bus.v_z = '0;
    hold_valid = 1'b0; withhold = 1'b0; go_now = 1'b0; stray_cyc = -1; stray_off = 0; done_lat = 1;
    test_reset();
    test_zero_frame();
    test_single_batch();
    test_partial_batch();
    test_inflight_stall();
    test_random_frames();
    test_underflow_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
